// File: rtl/alu_seq.sv
// Registered ALU: single-cycle AND/OR/ADD/SUB/SLT plus optional iterative
// MULTU (ALU_SEQ_MULT_EN) with start/busy/done handshake.
// Ports: clk, reset (async high), start, Signal (funct), dataA, dataB in;
// dataOut, dataHi, overflow, busy, done out.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] dataHi,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam logic [5:0] F_AND = 6'd36;
  localparam logic [5:0] F_OR  = 6'd37;
  localparam logic [5:0] F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_SLT = 6'd42;

  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             slt_lt;
  logic             a_s;
  logic             b_s;

  logic             idle;
  logic             mul_req;
  logic             mul_last;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  assign a_s     = dataA[WIDTH-1];
  assign b_s     = dataB[WIDTH-1];
  assign add_res = dataA + dataB;
  assign sub_res = dataA - dataB;

  // Sign-extended compare cannot overflow, unlike the sign of A-B.
  assign slt_lt = $signed({a_s, dataA})
                < $signed({b_s, dataB});

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (1'b1)
      (Signal == F_AND): alu_res = dataA & dataB;
      (Signal == F_OR):  alu_res = dataA | dataB;
      (Signal == F_ADD): begin
        alu_res = add_res;
        alu_ovf = (a_s == b_s)
                & (add_res[WIDTH-1] != a_s);
      end
      (Signal == F_SUB): begin
        alu_res = sub_res;
        alu_ovf = (a_s != b_s)
                & (sub_res[WIDTH-1] != a_s);
      end
      (Signal == F_SLT):
        alu_res = {{(WIDTH-1){1'b0}}, slt_lt};
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MULT_EN
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH:0]     psum;
  logic [CW-1:0]      cnt;

  assign idle     = (state == S_IDLE);
  assign mul_req  = idle & start
                  & (Signal == F_MULTU);
  assign mul_last = (state == S_MUL)
                  & (cnt == CW'(WIDTH - 1));

  // Carry of the partial add shifts into the product MSB.
  assign psum = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + (mplier[0] ? {1'b0, mcand}
                           : {(WIDTH+1){1'b0}});
  assign acc_nx  = {psum, acc[WIDTH-1:1]};
  assign prod_hi = acc_nx[2*WIDTH-1:WIDTH];
  assign prod_lo = acc_nx[WIDTH-1:0];

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (mul_req) state_nx = S_MUL;
      S_MUL:  if (mul_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (mul_req) begin
      mcand  <= dataA;
      mplier <= dataB;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_nx;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign idle     = 1'b1;
  assign mul_req  = 1'b0;
  assign mul_last = 1'b0;
  assign prod_hi  = '0;
  assign prod_lo  = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut  <= '0;
      dataHi   <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mul_last) begin
        dataHi   <= prod_hi;
        dataOut  <= prod_lo;
        overflow <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b1;
      end else if (mul_req) begin
        busy <= 1'b1;
      end else if (idle && start) begin
        dataOut  <= alu_res;
        overflow <= alu_ovf;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32).
// Expectations follow ALU_SEQ_MULT_EN when it is defined.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [5:0]   Signal;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic [W-1:0] dataOut;
  logic [W-1:0] dataHi;
  logic         overflow;
  logic         busy;
  logic         done;

  int n_chk;
  int n_fail;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .Signal   (Signal),
    .dataA    (dataA),
    .dataB    (dataB),
    .dataOut  (dataOut),
    .dataHi   (dataHi),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Drive one start; returns 1ns after the sampling edge.
  task automatic issue(input logic [5:0] f,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge clk);
    start  = 1'b1;
    Signal = f;
    dataA  = a;
    dataB  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_hi;
  int cyc;
  int both;
  int dones;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    start  = 1'b0;
    Signal = '0;
    dataA  = '0;
    dataB  = '0;
    tick();
    tick();
    check("rst_out", dataOut, 0);
    check("rst_hi", dataHi, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    issue(6'd32, 32'h7FFF_FFFF, 32'h1);
    check("add_out", dataOut, 64'h8000_0000);
    check("add_ovf", overflow, 1);
    check("add_done", done, 1);
    tick();
    check("add_done_drop", done, 0);
    check("add_hold", dataOut, 64'h8000_0000);

    issue(6'd34, 32'd5, 32'd7);
    check("sub_out", dataOut, 64'hFFFF_FFFE);
    check("sub_ovf", overflow, 0);
    check("sub_done", done, 1);
    issue(6'd42, 32'h8000_0000, 32'h1);
    check("slt_out", dataOut, 1);
    check("slt_done", done, 1);

    issue(6'd42, 32'h7FFF_FFFF, 32'h8000_0000);
    check("slt_neg", dataOut, 0);
    issue(6'd37, 32'hF0F0_F0F0, 32'h0F0F_0000);
    check("or_out", dataOut, 64'hFFFF_F0F0);
    issue(6'd32, 32'hFFFF_FFFF, 32'h1);
    check("add_wrap", dataOut, 0);
    check("add_wrap_ovf", overflow, 0);
    issue(6'd34, 32'h8000_0000, 32'h1);
    check("sub_ovf_out", dataOut, 64'h7FFF_FFFF);
    check("sub_ovf_flag", overflow, 1);

    issue(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef ALU_SEQ_MULT_EN
    check("mul_busy0", busy, 1);
    check("mul_done0", done, 0);
    cyc  = 1;
    both = 0;
    while (busy && cyc < 100) begin
      @(negedge clk);
      if (cyc == 5) begin
        start  = 1'b1;
        Signal = 6'd36;
        dataA  = 32'h1234_5678;
        dataB  = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (busy && done) both++;
      if (busy) cyc++;
    end
    start = 1'b0;
    check("mul_busy_cycles", cyc, 32);
    check("mul_busy_done", both, 0);
    check("mul_hi", dataHi, 64'hFFFF_FFFE);
    check("mul_lo", dataOut, 64'h1);
    check("mul_done", done, 1);
    check("mul_busy_end", busy, 0);
    check("mul_ovf", overflow, 0);
    tick();
    check("mul_done_drop", done, 0);
    check("mul_and_ignored", dataOut, 64'h1);
    exp_hi = 32'hFFFF_FFFE;
`else
    check("mulx_out", dataOut, 0);
    check("mulx_done", done, 1);
    check("mulx_busy", busy, 0);
    check("mulx_hi", dataHi, 0);
    check("mulx_ovf", overflow, 0);
    exp_hi = '0;
`endif

    issue(6'd34, 32'h8000_0000, 32'h1);
    check("sub_ovf2", overflow, 1);
    issue(6'h3F, 32'h1, 32'h1);
    check("unk_out", dataOut, 0);
    check("unk_ovf", overflow, 0);
    check("unk_done", done, 1);
    check("unk_hi", dataHi, exp_hi);
    tick();
    check("unk_done_drop", done, 0);

    issue(6'd25, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
`ifdef ALU_SEQ_MULT_EN
    #1;
    check("abort_busy_pre", busy, 1);
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_out", dataOut, 0);
    check("abort_hi", dataHi, 0);
    check("abort_ovf", overflow, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) dones++;
    end
    check("abort_no_done", dones, 0);

    issue(6'd36, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("and_out", dataOut, 64'hF000_F000);
    check("and_done", done, 1);
    check("and_hi", dataHi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
